// File: rtl/lm_sm_sequencer_if.sv
// ---------------------------------------------------------------------------
// lm_sm_sequencer_if
// Bundle between the fetch stage and the LM/SM sequencer.
//   master : fetch/hazard side. Drives the fetched instruction and the
//            pipeline control inputs, and consumes the IR-replacement outputs.
//   slave  : the sequencer itself.
// Signals:
//   IR_in        instruction word at fetch output (IROut)
//   IR_valid     IR_in is a real instruction, not a bubble
//   stall        downstream hazard stall
//   flush        control-flow redirect
//   IR_load_mux  1 = fetch takes new_IR_multi instead of imem data
//   new_IR_multi micro-op word produced by the sequencer
//   PCWrite_seq  0 = hold PC (ANDed into the fetch PCWrite)
//   busy         a multi-cycle sequence is in progress
// ---------------------------------------------------------------------------
interface lm_sm_sequencer_if;
    logic [15:0] IR_in;
    logic        IR_valid;
    logic        stall;
    logic        flush;
    logic        IR_load_mux;
    logic [15:0] new_IR_multi;
    logic        PCWrite_seq;
    logic        busy;

    modport master (
        output IR_in,
        output IR_valid,
        output stall,
        output flush,
        input  IR_load_mux,
        input  new_IR_multi,
        input  PCWrite_seq,
        input  busy
    );

    modport slave (
        input  IR_in,
        input  IR_valid,
        input  stall,
        input  flush,
        output IR_load_mux,
        output new_IR_multi,
        output PCWrite_seq,
        output busy
    );
endinterface

// File: rtl/lm_sm_sequencer.sv
// ---------------------------------------------------------------------------
// lm_sm_sequencer
// Expands LM/SM multi-register instructions into a run of single LW/SW
// micro-ops, lowest set mask bit first. The micro-op for the k-th issued bit i
// (k = 0..7) is:
//   LM -> {4'b0100, i, ra, 3'b000, k}   LW Ri <- mem[Ra+k]
//   SM -> {4'b0101, i, ra, 3'b000, k}   SW mem[Ra+k] <- Ri
// The first micro-op is produced straight from IR_in in IDLE; the remaining
// ones come from latched state in ISSUE while the PC is held so that the
// LM/SM word stays parked at fetch output. Every other opcode passes through.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    lm_sm_sequencer_if.slave (IR_in, IR_valid, stall, flush in;
//          IR_load_mux, new_IR_multi, PCWrite_seq, busy out)
// Parameters:
//   NOP_WORD  word issued for an LM/SM with an all-zero register mask
//
// Outputs are a combinational function of the registered state and IR_in:
// the first micro-op has to appear in the same cycle the LM/SM word is seen,
// so it cannot wait for a register stage.
// ---------------------------------------------------------------------------
module lm_sm_sequencer #(
    parameter logic [15:0] NOP_WORD = 16'hF000
) (
    input  logic                  clk,
    input  logic                  reset,
    lm_sm_sequencer_if.slave      bus
);

    localparam logic [3:0] OP_LM = 4'b0110;
    localparam logic [3:0] OP_SM = 4'b0111;
    localparam logic [3:0] OP_LW = 4'b0100;
    localparam logic [3:0] OP_SW = 4'b0101;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    // Index of the lowest set bit; 0 when the mask is empty (callers never
    // rely on the value in that case).
    function automatic logic [2:0] lowest_bit(input logic [7:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int j = 7; j >= 0; j--) begin
            if (m[j]) begin
                idx = 3'(j);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Build one LW/SW micro-op word.
    function automatic logic [15:0] micro_op(input logic       sm,
                                             input logic [2:0] rd,
                                             input logic [2:0] ra,
                                             input logic [2:0] k);
        return {(sm ? OP_SW : OP_LW), rd, ra, 3'b000, k};
    endfunction

    // Registered sequencing state
    state_t      st_r;
    logic [7:0]  rem_mask_r;
    logic [2:0]  base_r;
    logic        is_sm_r;
    logic [2:0]  cnt_r;

    // Decode of the incoming instruction
    logic [3:0]  op_s;
    logic [2:0]  ra_s;
    logic [7:0]  mask_s;
    logic        op_is_multi_s;
    logic        op_is_sm_s;
    logic        multi_s;
    logic [2:0]  idle_bit_s;
    logic [7:0]  idle_rest_s;
    logic [2:0]  issue_bit_s;
    logic [7:0]  issue_rest_s;

    // IR_in[8] has no meaning for LM/SM
    logic        unused_ir_bit_s;

    // Output drivers
    logic        load_mux_s;
    logic [15:0] word_s;
    logic        pcwrite_s;
    logic        busy_s;

    assign op_s            = bus.IR_in[15:12];
    assign ra_s            = bus.IR_in[11:9];
    assign mask_s          = bus.IR_in[7:0];
    assign unused_ir_bit_s = bus.IR_in[8];
    assign op_is_sm_s      = (op_s == OP_SM);
    assign op_is_multi_s   = (op_s == OP_LM) || op_is_sm_s;
    assign multi_s         = bus.IR_valid && op_is_multi_s && !bus.stall && !bus.flush;

    // Bit issued straight from IR_in, and what is left after it.
    assign idle_bit_s      = lowest_bit(mask_s);
    assign idle_rest_s     = mask_s & ~(8'd1 << idle_bit_s);

    // Bit issued from the latched mask, and what is left after it.
    assign issue_bit_s     = lowest_bit(rem_mask_r);
    assign issue_rest_s    = rem_mask_r & ~(8'd1 << issue_bit_s);

    // Output decode from state and the current instruction
    always_comb begin
        load_mux_s = 1'b0;
        word_s     = 16'h0000;
        pcwrite_s  = 1'b1;
        busy_s     = 1'b0;
        if (reset) begin
            load_mux_s = 1'b0;
            word_s     = 16'h0000;
            pcwrite_s  = 1'b1;
            busy_s     = 1'b0;
        end else begin
            case (st_r)
                ST_ISSUE: begin
                    busy_s = 1'b1;
                    if (bus.flush) begin
                        // Redirect abandons the sequence; let fetch follow the new path.
                        load_mux_s = 1'b0;
                        word_s     = 16'h0000;
                        pcwrite_s  = 1'b1;
                    end else begin
                        load_mux_s = 1'b1;
                        word_s     = micro_op(is_sm_r, issue_bit_s, base_r, cnt_r);
                        // Release the PC only in the cycle the final micro-op actually issues.
                        if (!bus.stall && (issue_rest_s == 8'd0)) begin
                            pcwrite_s = 1'b1;
                        end else begin
                            pcwrite_s = 1'b0;
                        end
                    end
                end
                ST_IDLE: begin
                    busy_s = 1'b0;
                    if (multi_s) begin
                        load_mux_s = 1'b1;
                        if (mask_s == 8'd0) begin
                            word_s    = NOP_WORD;
                            pcwrite_s = 1'b1;
                        end else begin
                            word_s = micro_op(op_is_sm_s, idle_bit_s, ra_s, 3'd0);
                            // A single-bit mask is done in this cycle; otherwise hold the PC.
                            if (idle_rest_s == 8'd0) begin
                                pcwrite_s = 1'b1;
                            end else begin
                                pcwrite_s = 1'b0;
                            end
                        end
                    end else begin
                        load_mux_s = 1'b0;
                        word_s     = 16'h0000;
                        pcwrite_s  = 1'b1;
                    end
                end
                default: begin
                    load_mux_s = 1'b0;
                    word_s     = 16'h0000;
                    pcwrite_s  = 1'b1;
                    busy_s     = 1'b0;
                end
            endcase
        end
    end

    assign bus.IR_load_mux  = load_mux_s;
    assign bus.new_IR_multi = word_s;
    assign bus.PCWrite_seq  = pcwrite_s;
    assign bus.busy         = busy_s;

    // Sequencer state machine
    always_ff @(posedge clk) begin
        if (reset) begin
            st_r       <= ST_IDLE;
            rem_mask_r <= 8'd0;
            cnt_r      <= 3'd0;
            base_r     <= 3'd0;
            is_sm_r    <= 1'b0;
        end else begin
            case (st_r)
                ST_IDLE: begin
                    if (bus.flush) begin
                        rem_mask_r <= 8'd0;
                        cnt_r      <= 3'd0;
                    end else if (multi_s && (idle_rest_s != 8'd0)) begin
                        // First micro-op went out this cycle; park the rest.
                        st_r       <= ST_ISSUE;
                        rem_mask_r <= idle_rest_s;
                        base_r     <= ra_s;
                        is_sm_r    <= op_is_sm_s;
                        cnt_r      <= 3'd1;
                    end else begin
                        st_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (bus.flush) begin
                        st_r       <= ST_IDLE;
                        rem_mask_r <= 8'd0;
                        cnt_r      <= 3'd0;
                    end else if (bus.stall) begin
                        // Hold everything; the same micro-op is shown again.
                        st_r <= ST_ISSUE;
                    end else if (issue_rest_s == 8'd0) begin
                        // Last bit issued; cnt is cleared rather than stepped
                        // so it never wraps after an eighth micro-op.
                        st_r       <= ST_IDLE;
                        rem_mask_r <= 8'd0;
                        cnt_r      <= 3'd0;
                    end else begin
                        rem_mask_r <= issue_rest_s;
                        cnt_r      <= cnt_r + 3'd1;
                    end
                end
                default: begin
                    st_r       <= ST_IDLE;
                    rem_mask_r <= 8'd0;
                    cnt_r      <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lm_sm_sequencer
// Directed vectors with hand-computed expected outputs. The stimulus process
// drives one vector per cycle just after the rising edge and pushes the
// expected response into a scoreboard queue; an independent monitor pops and
// compares on each falling edge.
// ---------------------------------------------------------------------------
module tb_lm_sm_sequencer;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    lm_sm_sequencer_if bus_if();

    lm_sm_sequencer #(.NOP_WORD(16'hF000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    typedef struct {
        string       name;
        logic        mux;
        logic [15:0] word;
        logic        chk_word;
        logic        pcw;
        logic        busy;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   tests_run    = 0;
    int   tests_failed = 0;

    // Drive one cycle of stimulus and record what the DUT must show for it.
    task automatic step(input string       name,
                        input logic [15:0] ir,
                        input logic        valid,
                        input logic        stl,
                        input logic        fl,
                        input logic        rst,
                        input logic        e_mux,
                        input logic [15:0] e_word,
                        input logic        e_chk_word,
                        input logic        e_pcw,
                        input logic        e_busy);
        exp_t e;
        @(posedge clk);
        #1;
        bus_if.IR_in    = ir;
        bus_if.IR_valid = valid;
        bus_if.stall    = stl;
        bus_if.flush    = fl;
        reset           = rst;
        e.name     = name;
        e.mux      = e_mux;
        e.word     = e_word;
        e.chk_word = e_chk_word;
        e.pcw      = e_pcw;
        e.busy     = e_busy;
        sb_q.push_back(e);
    endtask

    // Monitor: compare the DUT outputs for each driven cycle
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            tests_run++;
            if ((bus_if.IR_load_mux !== mon_e.mux) ||
                (mon_e.chk_word && (bus_if.new_IR_multi !== mon_e.word)) ||
                (bus_if.PCWrite_seq !== mon_e.pcw) ||
                (bus_if.busy !== mon_e.busy)) begin
                tests_failed++;
                $display("FAIL %s: got mux=%0b word=%h pcw=%0b busy=%0b, expected mux=%0b word=%h(chk=%0b) pcw=%0b busy=%0b",
                         mon_e.name, bus_if.IR_load_mux, bus_if.new_IR_multi,
                         bus_if.PCWrite_seq, bus_if.busy, mon_e.mux, mon_e.word,
                         mon_e.chk_word, mon_e.pcw, mon_e.busy);
            end
        end
    end

    logic [15:0] sm_words [8];
    logic [15:0] other_ops [6];

    initial begin
        sm_words[0] = 16'h5040; sm_words[1] = 16'h5241;
        sm_words[2] = 16'h5442; sm_words[3] = 16'h5643;
        sm_words[4] = 16'h5844; sm_words[5] = 16'h5A45;
        sm_words[6] = 16'h5C46; sm_words[7] = 16'h5E47;
        other_ops[0] = 16'h0000; other_ops[1] = 16'h1234;
        other_ops[2] = 16'h2345; other_ops[3] = 16'h4ABC;
        other_ops[4] = 16'h5ABC; other_ops[5] = 16'hF000;

        reset           = 1'b1;
        bus_if.IR_in    = 16'h0000;
        bus_if.IR_valid = 1'b0;
        bus_if.stall    = 1'b0;
        bus_if.flush    = 1'b0;

        // Reset holds outputs idle even with an LM presented
        step("reset_hold",  16'h64A1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        step("reset_hold2", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);

        // LM r2, 0xA1
        step("lm_a1_0", 16'h64A1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h4080, 1'b1, 1'b0, 1'b0);
        step("lm_a1_1", 16'h64A1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h4A81, 1'b1, 1'b0, 1'b1);
        step("lm_a1_2", 16'h64A1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h4E82, 1'b1, 1'b1, 1'b1);
        step("lm_a1_after", 16'h1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);

        // SM r1, 0xFF: eight micro-ops, PC released only on the last
        for (int i = 0; i < 8; i++) begin
            step("sm_ff", 16'h72FF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, sm_words[i], 1'b1,
                 (i == 7), (i != 0));
        end
        step("sm_ff_after", 16'h2345, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);

        // Empty mask -> NOP, stays idle
        step("lm_zero",  16'h6400, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hF000, 1'b1, 1'b1, 1'b0);
        step("lm_zero2", 16'h6400, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hF000, 1'b1, 1'b1, 1'b0);

        // Single bit -> one micro-op, no PC hold, stays idle
        step("lm_one",   16'h6408, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h4680, 1'b1, 1'b1, 1'b0);
        step("lm_one_after", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);

        // Stall in IDLE blocks the start
        step("idle_stall", 16'h64A1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);

        // LM 0xA1 with a two-cycle stall at the second micro-op
        step("stall_0", 16'h64A1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h4080, 1'b1, 1'b0, 1'b0);
        step("stall_1", 16'h64A1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h4A81, 1'b1, 1'b0, 1'b1);
        step("stall_2", 16'h64A1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h4A81, 1'b1, 1'b0, 1'b1);
        step("stall_3", 16'h64A1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h4A81, 1'b1, 1'b0, 1'b1);
        step("stall_4", 16'h64A1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h4E82, 1'b1, 1'b1, 1'b1);
        step("stall_after", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);

        // SM 0xFF flushed at the third micro-op
        step("flush_0", 16'h72FF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5040, 1'b1, 1'b0, 1'b0);
        step("flush_1", 16'h72FF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5241, 1'b1, 1'b0, 1'b1);
        step("flush_2", 16'h72FF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        step("flush_after", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);

        // Flush in IDLE suppresses an LM
        step("idle_flush", 16'h64A1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);

        // SM 0xFF reset at the third micro-op, then an ADD and a fresh LM
        step("rst_0", 16'h72FF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5040, 1'b1, 1'b0, 1'b0);
        step("rst_1", 16'h72FF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5241, 1'b1, 1'b0, 1'b1);
        step("rst_2", 16'h72FF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        step("rst_add", 16'h0123, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        step("rst_lm_0", 16'h64A1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h4080, 1'b1, 1'b0, 1'b0);
        step("rst_lm_1", 16'h64A1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h4A81, 1'b1, 1'b0, 1'b1);
        step("rst_lm_2", 16'h64A1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h4E82, 1'b1, 1'b1, 1'b1);

        // Non-multi opcodes pass through
        for (int i = 0; i < 6; i++) begin
            step("passthru", other_ops[i], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        end

        // Bubbles carrying LM/SM opcodes are ignored
        step("bubble_lm", 16'h64A1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        step("bubble_sm", 16'h72FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);

        // Bounded drain of the scoreboard
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (sb_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
